// File: rtl/seg_scan_decoder.sv
// Recovers a hex value from a multiplexed active-low 7-segment bus.
// Each digit must hold steady for STABLE_CYCLES samples before it is committed.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] sh_err_q, sh_err_d;
  logic [VW-1:0]         value_q, value_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic                  fv_q, fv_d;

  logic       sample_ok;
  logic       same;
  logic       commit;
  logic [4:0] dec;

  // Returns {illegal, nibble} for an active-low glyph (seg[6]=a .. seg[0]=g).
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0001100: r = 5'h09;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // Sample capture and stability run counter.
  always_comb begin
    an_d      = an;
    seg_d     = seg;
    sample_ok = $onehot(~an);
    same      = ({an, seg} == {an_q, seg_q});
    cnt_d     = '0;
    if (sample_ok) begin
      if (!same) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CNT_SAT) begin
        cnt_d = CNT_SAT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign commit = (cnt_q == CNT_HIT);
  assign dec    = seg_decode(seg_q);

  // Digit commit into the shadow frame and frame hand-off.
  always_comb begin
    shadow_d = shadow_q;
    sh_err_d = sh_err_q;
    seen_d   = seen_q;
    value_d  = value_q;
    err_d    = err_q;
    fv_d     = 1'b0;
    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_q[i]) begin
          shadow_d[4*i +: 4] = dec[3:0];
          sh_err_d[i]        = dec[4];
          seen_d[i]          = 1'b1;
        end
      end
      if (&seen_d) begin
        value_d = shadow_d;
        err_d   = sh_err_d;
        fv_d    = 1'b1;
        seen_d  = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '1;
      seg_q    <= '1;
      cnt_q    <= '0;
      seen_q   <= '0;
      shadow_q <= '0;
      sh_err_q <= '0;
      value_q  <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      sh_err_q <= sh_err_d;
      value_q  <= value_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random bus traffic
// checked against a sample-history reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;

  localparam logic [6:0] GLYPH [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [10:0] hist [$];
  logic [3:0]  m_sh [4];
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  logic [15:0] exp_value;
  logic [3:0]  exp_err;
  logic        exp_fv;

  seg_scan_decoder #(.STABLE_CYCLES(S), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .value(value), .digit_err(digit_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(input logic [10:0] x);
    logic [3:0] a;
    a = x[10:7];
    return $countones(~a) == 1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 4; i++) m_sh[i] = '0;
    m_err = '0;
    m_seen = '0;
    exp_value = '0;
    exp_err = '0;
    exp_fv = 1'b0;
  endtask

  // One clock edge seen by the model: a digit commits when the samples
  // just before this edge form an identical valid run of exactly S.
  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int run;
    int d;
    logic [10:0] last;
    logic [3:0] nib;
    logic bad;
    run = 0;
    exp_fv = 1'b0;
    if (hist.size() > 0) begin
      last = hist[hist.size()-1];
      if (is_valid(last)) begin
        for (int k = hist.size() - 1; k >= 0; k--) begin
          if (hist[k] != last) break;
          run++;
        end
      end
    end
    if (run == S) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!last[7+i]) d = i;
      nib = 4'h0;
      bad = 1'b1;
      for (int g = 0; g < 10; g++) begin
        if (GLYPH[g] == last[6:0]) begin
          nib = 4'(g);
          bad = 1'b0;
        end
      end
      m_sh[d] = nib;
      m_err[d] = bad;
      m_seen[d] = 1'b1;
      if (m_seen == 4'hf) begin
        exp_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        exp_err = m_err;
        exp_fv = 1'b1;
        m_seen = '0;
      end
    end
    hist.push_back({a, s});
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an = a;
    seg = s;
    @(posedge clk);
    model_edge(a, s);
    #1;
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("value", 32'(value), 32'(exp_value));
    chk("digit_err", 32'(digit_err), 32'(exp_err));
    if (frame_valid) pulses++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic scan4(input int d3, input int d2, input int d1,
                       input int d0);
    hold(4'b0111, GLYPH[d3], 8);
    hold(4'b1011, GLYPH[d2], 8);
    hold(4'b1101, GLYPH[d1], 8);
    hold(4'b1110, GLYPH[d0], 8);
  endtask

  // Async reset pulse, checked before any clock edge can act.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int n;
    rst_n = 1'b0;
    an = 4'hf;
    seg = 7'h7f;
    model_reset();
    #1;
    chk("init_value", 32'(value), 32'h0);
    chk("init_err", 32'(digit_err), 32'h0);
    chk("init_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    pulses = 0;
    scan4(1, 2, 3, 4);
    chk("scan_pulses", 32'(pulses), 32'd1);
    chk("scan_value", 32'(value), 32'h1234);
    chk("scan_err", 32'(digit_err), 32'h0);

    pulses = 0;
    hold(4'b0111, GLYPH[5], 8);
    hold(4'b1011, GLYPH[8], 3);
    hold(4'b1011, GLYPH[6], 8);
    hold(4'b1101, GLYPH[7], 8);
    hold(4'b1110, GLYPH[0], 8);
    chk("glitch_pulses", 32'(pulses), 32'd1);
    chk("glitch_value", 32'(value), 32'h5670);

    pulses = 0;
    hold(4'b0111, GLYPH[9], 8);
    hold(4'b1011, GLYPH[8], 8);
    hold(4'b1101, 7'b1111110, 8);
    hold(4'b1110, GLYPH[7], 8);
    chk("illegal_pulses", 32'(pulses), 32'd1);
    chk("illegal_value", 32'(value), 32'h9807);
    chk("illegal_err", 32'(digit_err), 32'h2);

    pulses = 0;
    hold(4'b0111, GLYPH[4], 8);
    hold(4'b1011, GLYPH[3], 8);
    hold(4'b1001, GLYPH[8], 20);
    hold(4'b1111, GLYPH[8], 20);
    chk("inv_no_pulse", 32'(pulses), 32'd0);
    hold(4'b1101, GLYPH[2], 8);
    hold(4'b1110, GLYPH[1], 8);
    chk("inv_pulses", 32'(pulses), 32'd1);
    chk("inv_value", 32'(value), 32'h4321);

    hold(4'b0111, GLYPH[9], 8);
    hold(4'b1011, GLYPH[9], 8);
    do_reset();
    pulses = 0;
    scan4(5, 6, 7, 8);
    chk("mrst_pulses", 32'(pulses), 32'd1);
    chk("mrst_value", 32'(value), 32'h5678);

    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(0, 9) < 8) a = ~(4'b1 << $urandom_range(0, 3));
      else a = 4'($urandom);
      if ($urandom_range(0, 9) < 8) s = GLYPH[$urandom_range(0, 9)];
      else s = 7'($urandom);
      n = $urandom_range(1, 9);
      hold(a, s, n);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
